// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: bank of NUM_REGS 8-bit registers written and read by an I2C
// slave front-end, with a host-side write port.
//
// I2C protocol: after rx_start, the first received byte is the register
// pointer (low bits). Every following byte is written to reg[ptr], and the
// pointer post-increments with wrap. Registers flagged in RO_MASK ignore I2C
// writes, but the pointer still advances. Each tx_req returns reg[ptr] and
// post-increments the pointer.
//
// Ports:
//   clock, reset_n          clock, async active-low reset
//   rx_start/rx_stop        transaction begin / end pulses
//   rx_valid, rx_byte       received byte pulse and data
//   tx_req                  slave wants the next byte
//   tx_byte, tx_valid       registered read data and its update pulse
//   host_we/addr/wdata      host-side write (ignores RO_MASK)
//   regs_flat               all registers, reg i at [8i+7:8i]
//   wr_strobe, wr_addr      pulse and address of each accepted I2C write
//   txn_done                pulse after rx_stop if the transaction wrote
module i2c_reg_bank #(
    parameter int                 NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 16'h8000,
    parameter logic [7:0]         RESET_VAL = 8'h00,
    localparam int                AW        = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rx_start,
    input  logic                  rx_stop,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_req,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [7:0]            host_wdata,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic                  txn_done
);

    typedef enum logic [1:0] {IDLE, GET_PTR, WRITE_DATA} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          written_q, written_d;
    logic          do_wr, do_tx, do_done;
    logic [7:0]    regs_q [NUM_REGS];

    // Next-state and event decode. Priority: rx_start over everything,
    // then rx_valid over tx_req; rx_stop is applied after any same-cycle
    // write so txn_done accounts for it.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        written_d = written_q;
        do_wr     = 1'b0;
        do_tx     = 1'b0;
        do_done   = 1'b0;
        if (rx_start) begin
            state_d   = GET_PTR;
            written_d = 1'b0;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    GET_PTR: begin
                        ptr_d   = rx_byte[AW-1:0];
                        state_d = WRITE_DATA;
                    end
                    WRITE_DATA: begin
                        do_wr = ~RO_MASK[ptr_q];
                        if (do_wr) written_d = 1'b1;
                        ptr_d = ptr_q + AW'(1);
                    end
                    default: ;
                endcase
            end else if (tx_req) begin
                do_tx = 1'b1;
                ptr_d = ptr_q + AW'(1);
            end
            if (rx_stop) begin
                state_d   = IDLE;
                do_done   = written_d;
                written_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            written_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            written_q <= written_d;
        end
    end

    // Register array: an I2C write to the same address overrides the host.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_wr && ptr_q == AW'(i))
                    regs_q[i] <= rx_byte;
                else if (host_we && host_addr == AW'(i))
                    regs_q[i] <= host_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            txn_done  <= 1'b0;
        end else begin
            tx_valid  <= do_tx;
            wr_strobe <= do_wr;
            txn_done  <= do_done;
            if (do_tx) tx_byte <= regs_q[ptr_q];
            if (do_wr) wr_addr <= ptr_q;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

endmodule
